// File: rtl/crane_pkg.sv
//==============================================================================
// crane_pkg
//------------------------------------------------------------------------------
// Shared definitions for the crane controller and its job scheduler:
//   - crane action codes (c_ACT_*)
//   - job_t: one queued lift job {bay id, target angle}
//   - sched_state_t: scheduler FSM states
//------------------------------------------------------------------------------
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

package crane_pkg;

  // Crane action codes, in the order the crane steps through a lift
  localparam logic [2:0] c_ACT_DN      = 3'b000;
  localparam logic [2:0] c_ACT_A1      = 3'b001;
  localparam logic [2:0] c_ACT_UP      = 3'b010;
  localparam logic [2:0] c_ACT_A2      = 3'b011;
  localparam logic [2:0] c_ACT_R1      = 3'b100;
  localparam logic [2:0] c_ACT_R2      = 3'b101;
  localparam logic [2:0] c_ACT_NOTHING = 3'b110;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] angle;
  } job_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_RUN    = 3'd2,
    S_RETURN = 3'd3,
    S_DONE   = 3'd4,
    S_FAULT  = 3'd5
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/crane_job_fifo.sv
//==============================================================================
// crane_job_fifo
//------------------------------------------------------------------------------
// Synchronous FIFO with binary wrap pointers (one extra MSB distinguishes
// full from empty).
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push, din       write request / data (accepted when not full, or when a
//                   pop happens in the same cycle)
//   pop, dout       read request / head data (pop ignored when empty)
//   full, empty     status
//   count           occupancy, 0..DEPTH
//------------------------------------------------------------------------------
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module crane_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wr == r_rd);
  assign full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign count = r_wr - r_rd;
  assign dout  = r_mem[r_rd[AW-1:0]];

  assign w_do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO lands
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/crane_job_scheduler.sv
//==============================================================================
// crane_job_scheduler
//------------------------------------------------------------------------------
// Round-robin arbiter for four loading bays feeding a job FIFO, and an FSM
// that issues one job at a time to the crane, routes the owning bay's
// hook/unhook strobes and detects completion or timeout.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req[3:0], angle[7:0]       per-bay request (level) and 2-bit target angle
//   hooked_i, unhooked_i       per-bay hook / unhook done strobes
//   crane_action[2:0]          action code reported by the crane
//   ack, done, fail [3:0]      per-bay one-cycle pulses
//   crane_write_mode           one-cycle job start
//   crane_mode_in[1:0]         target angle of the current job
//   crane_hooked/_unhooked     strobes of the owning bay (RUN only)
//   crane_rst                  one-cycle abort reset to the crane
//   busy, err                  FSM not idle / sticky timeout flag
//   count                      FIFO occupancy
//------------------------------------------------------------------------------
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module crane_job_scheduler
  import crane_pkg::*;
#(
  parameter int         DEPTH       = 4,
  parameter int         TIMEOUT     = 255,
  parameter int         RST_WAIT    = 2,
  parameter logic [2:0] ACT_NOTHING = c_ACT_NOTHING,
  parameter logic [2:0] ACT_R2      = c_ACT_R2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             req,
  input  logic [7:0]             angle,
  input  logic [3:0]             hooked_i,
  input  logic [3:0]             unhooked_i,
  input  logic [2:0]             crane_action,
  output logic [3:0]             ack,
  output logic [3:0]             done,
  output logic [3:0]             fail,
  output logic                   crane_write_mode,
  output logic [1:0]             crane_mode_in,
  output logic                   crane_hooked,
  output logic                   crane_unhooked,
  output logic                   crane_rst,
  output logic                   busy,
  output logic                   err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Arbiter
  logic [3:0]   r_ack;
  logic [1:0]   r_ptr;
  logic         r_push_vld;
  job_t         r_push_job;
  logic [3:0]   w_elig;
  logic         w_gnt_vld;
  logic [1:0]   w_gnt_id;
  logic         w_room;
  logic         w_grant;

  // FIFO
  job_t         w_head;
  logic         w_full;
  logic         w_empty;
  logic [CW-1:0] w_count;

  // FSM
  sched_state_t r_state;
  sched_state_t w_state_nxt;
  job_t         r_cur;
  logic [7:0]   r_timer;
  logic [7:0]   w_timer_inc;
  logic         w_tmo;
  logic         w_pop;
  logic         r_err;
  logic [3:0]   w_cur_onehot;
  logic         w_fault_entry;

  assign w_elig = req & ~r_ack;

  // First eligible bay at or after the pointer; scanning from the far end
  // lets the nearest offset win.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_elig[r_ptr + i[1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = r_ptr + i[1:0];
      end
    end
  end

  // The push lags the grant by a cycle, so room is judged on the occupancy
  // the FIFO will have when that push lands (pending push and current pop).
  always_comb begin
    if (w_pop)           w_room = 1'b1;
    else if (r_push_vld) w_room = (w_count < CW'(DEPTH - 1));
    else                 w_room = !w_full;
  end

  assign w_grant = w_gnt_vld && w_room;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack      <= '0;
      r_ptr      <= '0;
      r_push_vld <= 1'b0;
      r_push_job <= '0;
    end else begin
      r_ack      <= w_grant ? (4'b0001 << w_gnt_id) : 4'b0000;
      r_push_vld <= w_grant;
      if (w_grant) begin
        r_push_job <= '{id: w_gnt_id, angle: angle[2*w_gnt_id +: 2]};
        r_ptr      <= w_gnt_id + 2'd1;
      end
    end
  end

  crane_job_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(job_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r_push_vld),
    .din   (r_push_job),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_timer_inc = r_timer + 8'd1;
  // Timer reaches TIMEOUT on this edge; beats any action match
  assign w_tmo       = (w_timer_inc == 8'(TIMEOUT));

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE:  w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_tmo)                       w_state_nxt = S_FAULT;
        else if (crane_action == ACT_R2) w_state_nxt = S_RETURN;
      end
      S_RETURN: begin
        if (w_tmo)                            w_state_nxt = S_FAULT;
        else if (crane_action == ACT_NOTHING) w_state_nxt = S_DONE;
      end
      S_DONE:   w_state_nxt = S_IDLE;
      S_FAULT: begin
        if (r_timer == 8'(RST_WAIT)) w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_cur <= w_head;
      if (w_state_nxt == S_FAULT) r_err <= 1'b1;
      // Timer doubles as the FAULT hold counter: zeroed on FAULT entry,
      // so timer == 0 marks the entry cycle.
      case (r_state)
        S_ISSUE:          r_timer <= '0;
        S_RUN, S_RETURN:  r_timer <= (w_state_nxt == S_FAULT) ? 8'd0 : w_timer_inc;
        S_FAULT:          r_timer <= w_timer_inc;
        default:          r_timer <= r_timer;
      endcase
    end
  end

  assign w_cur_onehot  = 4'b0001 << r_cur.id;
  assign w_fault_entry = (r_state == S_FAULT) && (r_timer == 8'd0);

  assign ack              = r_ack;
  assign done             = (r_state == S_DONE) ? w_cur_onehot : 4'b0000;
  assign fail             = w_fault_entry ? w_cur_onehot : 4'b0000;
  assign crane_rst        = w_fault_entry;
  assign crane_write_mode = (r_state == S_ISSUE);
  // r_cur only loads on the IDLE pop, so this changes only entering ISSUE
  assign crane_mode_in    = r_cur.angle;
  assign crane_hooked     = (r_state == S_RUN) && hooked_i[r_cur.id];
  assign crane_unhooked   = (r_state == S_RUN) && unhooked_i[r_cur.id];
  assign busy             = (r_state != S_IDLE);
  assign err              = r_err;
  assign count            = w_count;

endmodule

`default_nettype wire

// File: doc/crane_job_scheduler.md
# crane_job_scheduler

Job scheduler in front of the single crane controller. It accepts lift jobs from four loading bays and arbitrates them round-robin into a small job FIFO. It then issues the jobs to the crane one at a time, routes the owning bay's hook/unhook strobes to the crane, and detects completion or timeout from the crane's action code. It sits between the bay interfaces and the crane's write_mode/mode_in/hooked/unhooked inputs.

## Interface
Parameters:
- DEPTH, 4: job FIFO entries; power of two, 2..8.
- TIMEOUT, 255: maximum cycles from issue to completion before the job is aborted.
- RST_WAIT, 2: cycles to hold off after a crane abort reset.
- ACT_NOTHING, 3'b110: crane idle action code.
- ACT_R2, 3'b101: crane "back at start height" action code.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req  in  4  per-bay job request, level; held until ack.
- angle  in  8  per-bay target angle; 2 bits per bay, bay k at [2k+1:2k]; stable while req[k] is high.
- hooked_i  in  4  per-bay hook-done strobe.
- unhooked_i  in  4  per-bay unhook-done strobe.
- crane_action  in  3  action code from the crane.
- ack  out  4  one-cycle accept pulse per bay.
- done  out  4  one-cycle job-complete pulse per bay.
- fail  out  4  one-cycle job-aborted pulse per bay.
- crane_write_mode  out  1  one-cycle job start to the crane.
- crane_mode_in  out  2  target angle; held for the whole job.
- crane_hooked  out  1  muxed hook strobe.
- crane_unhooked  out  1  muxed unhook strobe.
- crane_rst  out  1  one-cycle abort reset to the crane.
- busy  out  1  high whenever the FSM is not in IDLE.
- err  out  1  sticky timeout flag; cleared only by reset.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Reset values: every output is 0, FSM is IDLE, FIFO is empty, round-robin pointer = 0 (bay 0 has highest priority first).
- Arbiter:
  - Eligible set = req & ~ack (masks a bay acked in the previous cycle).
  - When the FIFO is not full, grant the first eligible bay at or after the pointer, modulo 4.
  - On a grant, push {id[1:0], angle[id]}, register ack[id] for the next cycle, and move the pointer to id+1 (wrapping 3 to 0).
  - When the FIFO is full, there is no grant and the pointer holds.
- FIFO: binary read/write pointers with wrap. A push and a pop in the same cycle are legal, including when the FIFO is full (pop frees the slot in the same cycle) or empty (no pop occurs, so the push lands).
- FSM states and transitions:
  - IDLE: if count != 0, pop the head into cur_id/cur_angle and go to ISSUE.
  - ISSUE: crane_write_mode = 1 for exactly this cycle; crane_mode_in = cur_angle from this cycle until the FSM leaves RETURN; clear the timer; go to RUN.
  - RUN: crane_hooked = hooked_i[cur_id] and crane_unhooked = unhooked_i[cur_id], passed through combinationally; both are 0 in every other state. When crane_action == ACT_R2, go to RETURN.
  - RETURN: when crane_action == ACT_NOTHING, go to DONE.
  - DONE: pulse done[cur_id]; go to IDLE.
  - FAULT: pulse fail[cur_id] and crane_rst on entry; set err; hold for RST_WAIT cycles; go to IDLE.
- Timer: 8-bit counter, incremented in RUN and RETURN. When it reaches TIMEOUT, go to FAULT; timeout takes priority over a same-cycle action match.
- Angle 0 is a legal job: the crane skips rotation, and the scheduler behaves identically.
- A bay may have several jobs queued; there is no per-bay exclusion.
- Reset mid-job: all state and the FIFO are cleared, pending jobs are dropped without a fail pulse, and crane_rst is not asserted.

## Timing
- Request to ack: req rises in cycle t, ack is high in cycle t+1 when the FIFO has room and the bay wins arbitration.
- With an empty FIFO and an idle FSM:
  - push in t+1 (count = 1 in t+2)
  - IDLE pop in t+2
  - crane_write_mode high in t+3
- done/fail fire exactly one cycle after the terminating condition is sampled.
- Back-to-back jobs: minimum of 3 cycles from done to the next crane_write_mode (DONE, IDLE, ISSUE).
- crane_mode_in changes only in ISSUE.

## Structure
- Shared package crane_pkg holds:
  - the action codes (dn, A1, up, A2, r1, r2, nothing)
  - the job typedef {logic [1:0] id; logic [1:0] angle;}
  - the scheduler FSM state enum
- The crane controller is to take its action codes from crane_pkg as well.
- One sub-module: crane_job_fifo, a parameterised synchronous FIFO with push/pop/full/empty/count.
- The arbiter and FSM live in the top level.

## Test plan
- Single job: bay 2 requests angle 3 → ack[2] at t+1, crane_write_mode at t+3, crane_mode_in = 3; model action r2 then nothing → done[2] one cycle later.
- Contention: all four bays request at once with the pointer at 0 → acks in order 0, 1, 2, 3 on consecutive cycles; jobs execute in that order.
- Full FIFO (DEPTH = 4, crane stalled): a fifth request receives no ack until the first pop; then ack arrives the cycle after the pop, and count never exceeds 4.
- Strobe routing: bay 1's job is running and hooked_i = 4'b0101 → crane_hooked = 0; hooked_i[1] = 1 → crane_hooked = 1 in the same cycle.
- Timeout (TIMEOUT = 20): crane_action stuck at dn → fail[cur_id] and crane_rst at cycle 20 after RUN entry; err is sticky; the next queued job issues RST_WAIT + 2 cycles later.
- Reset asserted during RUN with 2 jobs queued → all outputs 0 immediately, count = 0, and no done/fail pulses.
